jtframe_joyser: RTL and testbench

JTFRAME_JOYSER -- requirements
Module: jtframe_joyser

---
 rtl/jtframe_joyser_pkg.sv | 17 +
 rtl/jtframe_joyser_tick.sv | 25 ++
 rtl/jtframe_joyser.sv | 116 +++++++++++
 tb/tb_jtframe_joyser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_joyser_pkg.sv
// Shared types and helpers for the serial joystick reader.
package jtframe_joyser_pkg;

    // Reader sequence: idle gap, parallel load, then alternating sample / clock-high.
    typedef enum logic [1:0] {
        ST_GAP    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_CLKHI  = 2'd3
    } joy_state_e;

    // Sample k arrives MSB-first within each joystick; return its joy_o bit position.
    function automatic int unsigned sample_bit(input int unsigned k, input int unsigned bits);
        return (k / bits) * bits + (bits - 1 - (k % bits));
    endfunction

endpackage

// File: rtl/jtframe_joyser_tick.sv
// Shift-rate divider: one-cycle tick every DIV clk cycles, registered.
module jtframe_joyser_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    // Counter 0..DIV-1; tick is asserted while the counter sits at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
            tick <= (cnt == CW'(DIV - 2));
        end
    end

endmodule

// File: rtl/jtframe_joyser.sv
// Serial (shift-register chain) joystick reader.
// Optional feature: define JTFRAME_JOYSER_DEBOUNCE_EN to publish a frame only
// when it matches the previously captured frame.
module jtframe_joyser
    import jtframe_joyser_pkg::*;
#(
    parameter int unsigned JOYS = 2,
    parameter int unsigned BITS = 6,
    parameter int unsigned DIV  = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   joy_data_i,
    output logic                   joy_clk_o,
    output logic                   joy_load_o,
    output logic [JOYS*BITS-1:0]   joy_o,
    output logic                   frame_o
);

    localparam int unsigned N   = JOYS * BITS;
    localparam int unsigned BCW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GCW = $clog2(GAP + 1);

    logic              tick;
    joy_state_e        state;
    logic [GCW-1:0]    gap_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [N-1:0]      sh_q;
    logic [N-1:0]      capture_c;
    logic              last_c;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    logic [N-1:0]      prev_q;
`endif

    jtframe_joyser_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Capture vector including the bit being sampled this tick.
    always_comb begin
        capture_c = sh_q;
        capture_c[BCW'(sample_bit(32'(bit_cnt), BITS))] = joy_data_i;
    end

    assign last_c = (bit_cnt == BCW'(N - 1));

    // Frame sequencer; outputs are set alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_GAP;
            gap_cnt    <= GCW'(GAP);
            bit_cnt    <= '0;
            joy_load_o <= 1'b1;
            joy_clk_o  <= 1'b0;
            joy_o      <= '1;
            frame_o    <= 1'b0;
            sh_q       <= '1;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
            prev_q     <= '1;
`endif
        end else begin
            frame_o <= 1'b0;
            if (tick) begin
                case (state)
                    ST_GAP: begin
                        if (gap_cnt == GCW'(1)) begin
                            state      <= ST_LOAD;
                            joy_load_o <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state      <= ST_SAMPLE;
                        joy_load_o <= 1'b1;
                    end
                    ST_SAMPLE: begin
                        sh_q <= capture_c;
                        if (last_c) begin
                            // No clock-high after the final bit; publish straight away.
                            state   <= ST_GAP;
                            gap_cnt <= GCW'(GAP);
                            bit_cnt <= '0;
                            frame_o <= 1'b1;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
                            if (capture_c == prev_q) begin
                                joy_o <= capture_c;
                            end
                            prev_q <= capture_c;
`else
                            joy_o <= capture_c;
`endif
                        end else begin
                            state     <= ST_CLKHI;
                            joy_clk_o <= 1'b1;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                    ST_CLKHI: begin
                        state     <= ST_SAMPLE;
                        joy_clk_o <= 1'b0;
                    end
                    default: begin
                        state <= ST_GAP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_joyser.sv
// Self-checking bench for jtframe_joyser: default configuration plus the
// widest/fastest configuration, each fed by a behavioural shift-register chain.
module tb_jtframe_joyser;

    localparam int unsigned J  = 2,  B  = 6,  D  = 4, G  = 1, N  = J * B;
    localparam int unsigned JX = 4,  BX = 16, DX = 2, GX = 1, NX = JX * BX;
    localparam int PER  = (2 * N + G) * D;
    localparam int PERX = (2 * NX + GX) * DX;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_x;
    logic noise = 1'b0;

    // Default-configuration DUT and chain
    logic [N-1:0]  pat = '1, lat = '1;
    int unsigned   idx = 0;
    logic          ck_d = 1'b0;
    logic          data, joy_clk, joy_load, frame;
    logic [N-1:0]  joy;

    // Extreme-configuration DUT and chain
    logic [NX-1:0] pat_x = '1, lat_x = '1;
    int unsigned   idx_x = 0;
    logic          ck_dx = 1'b0;
    logic          data_x, joy_clk_x, joy_load_x, frame_x;
    logic [NX-1:0] joy_x;

    jtframe_joyser #(.JOYS(J), .BITS(B), .DIV(D), .GAP(G)) dut (
        .clk(clk), .rst(rst), .joy_data_i(data), .joy_clk_o(joy_clk),
        .joy_load_o(joy_load), .joy_o(joy), .frame_o(frame));

    jtframe_joyser #(.JOYS(JX), .BITS(BX), .DIV(DX), .GAP(GX)) dut_x (
        .clk(clk), .rst(rst_x), .joy_data_i(data_x), .joy_clk_o(joy_clk_x),
        .joy_load_o(joy_load_x), .joy_o(joy_x), .frame_o(frame_x));

    // Chain output for shift position k: joystick k/bits, sending its MSB first.
    function automatic logic chain_bit(input logic [63:0] v, input int unsigned k, input int unsigned bits);
        logic [63:0] s;
        s = v >> ((k / bits) * bits + (bits - 1 - (k % bits)));
        return s[0];
    endfunction

    always @(posedge clk) noise <= 1'($urandom);

    // Behavioural 74HC165-style chains: latch on load low, advance on clock rise.
    always @(posedge clk) begin
        ck_d  <= joy_clk;
        ck_dx <= joy_clk_x;
        if (!joy_load) begin idx <= 0; lat <= pat; end
        else if (joy_clk && !ck_d) idx <= idx + 1;
        if (!joy_load_x) begin idx_x <= 0; lat_x <= pat_x; end
        else if (joy_clk_x && !ck_dx) idx_x <= idx_x + 1;
    end

    // Outside a valid sample window the line carries random garbage.
    assign data   = (!joy_load   || joy_clk   || idx   >= N ) ? noise : chain_bit(64'(lat),  idx,   B);
    assign data_x = (!joy_load_x || joy_clk_x || idx_x >= NX) ? noise : chain_bit(64'(lat_x), idx_x, BX);

    int nchk = 0, npass = 0;
    logic [63:0] m_joy, m_prev, mx_joy, mx_prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: what joy_o shows after a frame captures cap.
    task automatic model_upd(input logic [63:0] cap, inout logic [63:0] mj, inout logic [63:0] mp);
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
        if (cap == mp) mj = cap;
        mp = cap;
`else
        mj = cap;
        mp = cap;
`endif
    endtask

    task automatic wait_frame(output int cyc, output int lows, output int pulses,
                              output bit ok, output bit stable);
        logic [N-1:0] j0;
        logic pc;
        j0 = joy; pc = joy_clk;
        cyc = 0; lows = 0; pulses = 0; ok = 0; stable = 1;
        while (!ok && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!joy_load) lows++;
            if (joy_clk && !pc) pulses++;
            pc = joy_clk;
            if (frame) ok = 1;
            else if (joy !== j0) stable = 0;
        end
    endtask

    task automatic wait_frame_x(output int cyc, output bit ok);
        cyc = 0; ok = 0;
        while (!ok && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (frame_x) ok = 1;
        end
    endtask

    task automatic frame_step(input string tag, input bit chk_timing);
        int cyc, lows, pulses;
        bit ok, stable;
        wait_frame(cyc, lows, pulses, ok, stable);
        check({tag, "_seen"}, 64'(ok), 64'(1));
        model_upd(64'(pat), m_joy, m_prev);
        check({tag, "_joy"}, 64'(joy), m_joy);
        check({tag, "_stable"}, 64'(stable), 64'(1));
        if (chk_timing) begin
            check({tag, "_period"}, 64'(cyc), 64'(PER));
            check({tag, "_load_low"}, 64'(lows), 64'(D));
            check({tag, "_clk_pulses"}, 64'(pulses), 64'(N - 1));
        end
    endtask

    initial begin
        int cyc, cnt;
        bit ok, seen_frame;

        rst = 1'b1; rst_x = 1'b1;
        m_joy = 64'hFFF; m_prev = 64'hFFF;
        mx_joy = '1; mx_prev = '1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_joy",   64'(joy),      64'hFFF);
        check("rst_load",  64'(joy_load), 64'(1));
        check("rst_clk",   64'(joy_clk),  64'(0));
        check("rst_frame", 64'(frame),    64'(0));
        check("rst_joy_x", joy_x,         '1);
        rst = 1'b0; rst_x = 1'b0;

        // First frame after reset arrives one full period later
        begin
            int lows, pulses;
            bit stable;
            wait_frame(cyc, lows, pulses, ok, stable);
            check("first_seen", 64'(ok), 64'(1));
            check("first_latency", 64'(cyc), 64'(PER));
            model_upd(64'(pat), m_joy, m_prev);
            check("first_joy", 64'(joy), m_joy);
        end

        // Mapping: joystick0=111110, joystick1=011111, held two frames
        pat = {6'b011111, 6'b111110};
        frame_step("map1", 1'b1);
        frame_step("map2", 1'b1);
        check("map_const", 64'(joy), 64'(12'b011111_111110));

        // Random patterns, some held for a second frame
        for (int i = 0; i < 6; i++) begin
            pat = 12'($urandom);
            frame_step("rand", 1'b1);
            if (i[0]) frame_step("rand_hold", 1'b1);
        end

        // Single-frame glitch
        pat = 12'hFFF;
        frame_step("pre_glitch_a", 1'b1);
        frame_step("pre_glitch_b", 1'b1);
        pat = 12'hFFE;
        frame_step("glitch", 1'b1);
        pat = 12'hFFF;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
        check("deb_glitch_held_off", 64'(joy), 64'hFFF);
        frame_step("deb_after", 1'b1);
        check("deb_after_const", 64'(joy), 64'hFFF);
        pat = 12'hFFE;
        frame_step("deb_hold1", 1'b1);
        check("deb_hold1_const", 64'(joy), 64'hFFF);
        frame_step("deb_hold2", 1'b1);
        check("deb_hold2_const", 64'(joy), 64'hFFE);
`else
        check("glitch_const", 64'(joy), 64'hFFE);
        cnt = 0;
        while (joy === 12'hFFE && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("glitch_duration", 64'(cnt), 64'(PER));
        check("glitch_cleared", 64'(joy), 64'hFFF);
        model_upd(64'(pat), m_joy, m_prev);
`endif

        // Reset in the middle of a frame, during the 6th sample
        pat = 12'h5A3;
        cnt = 0;
        begin
            logic pc;
            pc = joy_clk;
            cyc = 0;
            while (cnt < 5 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (joy_clk && !pc) cnt++;
                pc = joy_clk;
            end
            while (joy_clk && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("midrst_reached", 64'(cnt), 64'(5));
        rst = 1'b1;
        seen_frame = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame) seen_frame = 1;
        end
        check("midrst_joy",  64'(joy),      64'hFFF);
        check("midrst_load", 64'(joy_load), 64'(1));
        check("midrst_clk",  64'(joy_clk),  64'(0));
        m_joy = 64'hFFF; m_prev = 64'hFFF;
        rst = 1'b0;
        cnt = 0;
        while (joy_load && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (frame) seen_frame = 1;
        end
        check("midrst_no_frame", 64'(seen_frame), 64'(0));
        check("midrst_load_delay", 64'(cnt), 64'(G * D));
        begin
            int lows, pulses;
            bit stable;
            wait_frame(cyc, lows, pulses, ok, stable);
            check("midrst_seen", 64'(ok), 64'(1));
            check("midrst_to_frame", 64'(cyc), 64'(PER - G * D));
            model_upd(64'(pat), m_joy, m_prev);
            check("midrst_joy1", 64'(joy), m_joy);
        end
        frame_step("midrst_next", 1'b1);
        check("midrst_const", 64'(joy), 64'h5A3);

        // Extreme configuration: 4x16 bits at DIV=2
        wait_frame_x(cyc, ok);
        check("x_sync", 64'(ok), 64'(1));
        for (int i = 0; i < 10; i++) begin
            pat_x = {$urandom, $urandom};
            repeat (2) begin
                wait_frame_x(cyc, ok);
                check("x_seen", 64'(ok), 64'(1));
                check("x_period", 64'(cyc), 64'(PERX));
                model_upd(pat_x, mx_joy, mx_prev);
                check("x_joy", joy_x, mx_joy);
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
